// File: rtl/core_lsu.sv
// core_lsu: load/store unit sitting downstream of the ALU.
//
// Handles byte/half/word loads and stores and word AMOs over a single-outstanding memory bus.
// For an AMO the loaded word is presented to the ALU on amo_rdata_o. The ALU result comes back
// on amo_wdata_i and is written to memory. The old value is returned as the response.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   req_valid_i/ready_o   request handshake; ready only while idle
//   lsu_op_i, addr_i      operation code and effective address (ALU sum)
//   wdata_i               store data (rs2)
//   amo_rdata_o           latched AMO read value, ALU src_a operand
//   amo_wdata_i           ALU result for AMO write-back
//   mem_*                 memory bus; mem_ready_i is a one-cycle ack with read data
//   resp_*                one-cycle completion pulse with data and misalignment flag
module core_lsu (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [3:0]  lsu_op_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] amo_rdata_o,
  input  logic [31:0] amo_wdata_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_wstrb_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_rdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_data_o,
  output logic        resp_misaligned_o
);

  localparam logic [3:0] OpLb  = 4'd0;
  localparam logic [3:0] OpLh  = 4'd1;
  localparam logic [3:0] OpLw  = 4'd2;
  localparam logic [3:0] OpLbu = 4'd4;
  localparam logic [3:0] OpLhu = 4'd5;
  localparam logic [3:0] OpSb  = 4'd8;
  localparam logic [3:0] OpSh  = 4'd9;
  localparam logic [3:0] OpSw  = 4'd10;
  localparam logic [3:0] OpAmo = 4'd14;

  typedef enum logic [2:0] {StIdle, StRead, StCalc, StWrite, StResp} state_e;

  state_e      state_q;
  logic [3:0]  op_q;
  logic [1:0]  addr_lo_q;
  logic        mem_req_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [3:0]  mem_wstrb_q;
  logic [31:0] mem_wdata_q;
  logic        resp_valid_q;
  logic [31:0] resp_data_q;
  logic        resp_misaligned_q;
  logic [31:0] amo_rdata_q;

  // Request decode, evaluated on the incoming request.
  logic        misaligned;
  logic        is_store;
  logic        is_amo;
  logic [3:0]  st_strb;
  logic [31:0] st_wdata;

  always_comb begin
    misaligned = 1'b0;
    case (lsu_op_i)
      OpLh, OpLhu, OpSh: misaligned = addr_i[0];
      OpLw, OpSw, OpAmo: misaligned = |addr_i[1:0];
      default:           misaligned = 1'b0;
    endcase
    is_store = (lsu_op_i == OpSb) || (lsu_op_i == OpSh) || (lsu_op_i == OpSw);
    is_amo   = (lsu_op_i == OpAmo);
    st_strb  = 4'b1111;
    st_wdata = wdata_i;
    case (lsu_op_i)
      OpSb: begin
        st_strb  = 4'b0001 << addr_i[1:0];
        st_wdata = {4{wdata_i[7:0]}};
      end
      OpSh: begin
        st_strb  = addr_i[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{wdata_i[15:0]}};
      end
      OpSw, OpAmo: begin
        st_strb  = 4'b1111;
        st_wdata = wdata_i;
      end
      // Loads drive no strobes and no data.
      default: begin
        st_strb  = 4'b0000;
        st_wdata = 32'h0;
      end
    endcase
  end

  // Load extraction from the returned word, using the latched op and byte offset.
  logic [31:0] rd_shifted;
  logic [31:0] ld_data;

  always_comb begin
    rd_shifted = mem_rdata_i >> {addr_lo_q, 3'b000};
    case (op_q)
      OpLb:    ld_data = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
      OpLh:    ld_data = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
      OpLbu:   ld_data = {24'h0, rd_shifted[7:0]};
      OpLhu:   ld_data = {16'h0, rd_shifted[15:0]};
      default: ld_data = mem_rdata_i;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q           <= StIdle;
      op_q              <= 4'h0;
      addr_lo_q         <= 2'b00;
      mem_req_q         <= 1'b0;
      mem_we_q          <= 1'b0;
      mem_addr_q        <= 32'h0;
      mem_wstrb_q       <= 4'h0;
      mem_wdata_q       <= 32'h0;
      resp_valid_q      <= 1'b0;
      resp_data_q       <= 32'h0;
      resp_misaligned_q <= 1'b0;
      amo_rdata_q       <= 32'h0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            op_q        <= lsu_op_i;
            addr_lo_q   <= addr_i[1:0];
            mem_addr_q  <= {addr_i[31:2], 2'b00};
            resp_data_q <= 32'h0;
            if (misaligned) begin
              resp_valid_q      <= 1'b1;
              resp_misaligned_q <= 1'b1;
              state_q           <= StResp;
            end else begin
              resp_misaligned_q <= 1'b0;
              mem_req_q         <= 1'b1;
              mem_we_q          <= is_store;
              mem_wstrb_q       <= st_strb;
              mem_wdata_q       <= st_wdata;
              state_q           <= is_store ? StWrite : StRead;
            end
          end
        end
        StRead: begin
          if (mem_ready_i) begin
            mem_req_q <= 1'b0;
            if (op_q == OpAmo) begin
              amo_rdata_q <= mem_rdata_i;
              state_q     <= StCalc;
            end else begin
              resp_data_q  <= ld_data;
              resp_valid_q <= 1'b1;
              state_q      <= StResp;
            end
          end
        end
        // One cycle for the ALU to combine amo_rdata_o with its other operand.
        StCalc: begin
          mem_wdata_q <= amo_wdata_i;
          resp_data_q <= amo_rdata_q;
          mem_req_q   <= 1'b1;
          mem_we_q    <= 1'b1;
          state_q     <= StWrite;
        end
        StWrite: begin
          if (mem_ready_i) begin
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            resp_valid_q <= 1'b1;
            state_q      <= StResp;
          end
        end
        StResp: begin
          resp_valid_q <= 1'b0;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Ready is a pure decode of the idle state, so it is high straight out of reset.
  assign req_ready_o       = (state_q == StIdle);
  assign amo_rdata_o       = amo_rdata_q;
  assign mem_req_o         = mem_req_q;
  assign mem_we_o          = mem_we_q;
  assign mem_addr_o        = mem_addr_q;
  assign mem_wstrb_o       = mem_wstrb_q;
  assign mem_wdata_o       = mem_wdata_q;
  assign resp_valid_o      = resp_valid_q;
  assign resp_data_o       = resp_data_q;
  assign resp_misaligned_o = resp_misaligned_q;

endmodule

// File: tb/tb_core_lsu.sv
// tb_core_lsu: self-checking bench for core_lsu with a bus responder, an ADD ALU
// on the AMO path and an arithmetic reference model of load/store formatting.
module tb_core_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  lsu_op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] amo_rdata;
  logic [31:0] amo_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_misaligned;
  logic [31:0] alu_b;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // ALU configured as ADD for AMOs.
  assign amo_wdata = amo_rdata + alu_b;

  core_lsu dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .lsu_op_i         (lsu_op),
    .addr_i           (addr),
    .wdata_i          (wdata),
    .amo_rdata_o      (amo_rdata),
    .amo_wdata_i      (amo_wdata),
    .mem_req_o        (mem_req),
    .mem_we_o         (mem_we),
    .mem_addr_o       (mem_addr),
    .mem_wstrb_o      (mem_wstrb),
    .mem_wdata_o      (mem_wdata),
    .mem_ready_i      (mem_ready),
    .mem_rdata_i      (mem_rdata),
    .resp_valid_o     (resp_valid),
    .resp_data_o      (resp_data),
    .resp_misaligned_o(resp_misaligned)
  );

  localparam logic [3:0] LB = 0, LH = 1, LW = 2, LBU = 4, LHU = 5, SB = 8, SH = 9, SW = 10,
                         AMO = 14;

  typedef struct {
    int          resp_cyc;
    logic [31:0] data;
    logic        mis;
    int          nrd;
    int          nwr;
    logic [31:0] raddr;
    logic [31:0] waddr;
    logic [31:0] wdat;
    logic [3:0]  wstrb;
    logic        stable;
    logic        rdy_low;
    logic        idle_after;
    logic [31:0] amo_seen;
  } obs_t;

  // ---------------- reference model ----------------
  function automatic bit is_load(input logic [3:0] op);
    return op == LB || op == LH || op == LW || op == LBU || op == LHU;
  endfunction

  function automatic bit is_st(input logic [3:0] op);
    return op == SB || op == SH || op == SW;
  endfunction

  function automatic bit model_mis(input logic [3:0] op, input logic [31:0] a);
    if (op == LH || op == LHU || op == SH) return (a % 2) != 0;
    if (op == LW || op == SW || op == AMO) return (a % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] rd);
    logic [31:0] v;
    v = rd / (32'd1 << (8 * (a % 4)));
    case (op)
      LB:      begin v = v % 256;   return (v >= 128) ? v + 32'hFFFF_FF00 : v; end
      LH:      begin v = v % 65536; return (v >= 32768) ? v + 32'hFFFF_0000 : v; end
      LBU:     return v % 256;
      LHU:     return v % 65536;
      default: return rd;
    endcase
  endfunction

  function automatic logic [3:0] model_strb(input logic [3:0] op, input logic [31:0] a);
    if (op == SB) return 4'(1 << (a % 4));
    if (op == SH) return (a % 4 >= 2) ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [3:0] op, input logic [31:0] wd);
    if (op == SB) return (wd % 256) * 32'h0101_0101;
    if (op == SH) return (wd % 65536) * 32'h0001_0001;
    return wd;
  endfunction

  // ---------------- driver / bus responder ----------------
  // Issues one request at a negedge and plays the memory until the response, then one more
  // cycle so the unit is back in idle. Observations only; comparisons are in the callers.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input int rw, input int ww, output obs_t o);
    bit          active;
    int          cnt;
    int          wt;
    logic        p_we;
    logic [31:0] p_addr;
    logic [3:0]  p_strb;
    logic [31:0] p_wdata;
    o = '{resp_cyc: -1, data: 32'h0, mis: 1'b0, nrd: 0, nwr: 0, raddr: 32'h0, waddr: 32'h0,
          wdat: 32'h0, wstrb: 4'h0, stable: 1'b1, rdy_low: 1'b1, idle_after: 1'b0,
          amo_seen: 32'hDEAD_BEEF};
    active = 0;
    cnt = 0;
    @(negedge clk);
    req_valid = 1'b1;
    lsu_op = op;
    addr = a;
    wdata = wd;
    alu_b = wd;
    mem_ready = 1'b0;
    for (int n = 1; n <= 40 && o.resp_cyc < 0; n++) begin
      @(negedge clk);
      // Scramble the request inputs: the unit must have latched them.
      req_valid = 1'b0;
      lsu_op = 4'($urandom);
      addr = $urandom;
      wdata = $urandom;
      if (req_ready) o.rdy_low = 1'b0;
      if (resp_valid) begin
        o.resp_cyc = n;
        o.data = resp_data;
        o.mis = resp_misaligned;
      end
      if (mem_req) begin
        if (!active) begin
          active = 1;
          cnt = 0;
          p_we = mem_we; p_addr = mem_addr; p_strb = mem_wstrb; p_wdata = mem_wdata;
          if (mem_we) o.nwr++; else o.nrd++;
        end else if (p_we !== mem_we || p_addr !== mem_addr || p_strb !== mem_wstrb ||
                     p_wdata !== mem_wdata) begin
          o.stable = 1'b0;
        end
        wt = mem_we ? ww : rw;
        mem_ready = (cnt == wt);
        mem_rdata = (cnt == wt) ? rd : $urandom;
        if (cnt == wt) begin
          active = 0;
          if (mem_we) begin
            o.waddr = mem_addr; o.wdat = mem_wdata; o.wstrb = mem_wstrb;
          end else begin
            o.raddr = mem_addr;
          end
        end
        cnt++;
      end else begin
        // Stray acknowledges outside a bus phase must be ignored.
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        if (!resp_valid && n > 1) o.amo_seen = amo_rdata;
      end
    end
    @(negedge clk);
    mem_ready = 1'b0;
    o.idle_after = req_ready;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req_valid = 1'($urandom_range(0, 1));
      lsu_op = LW;
      addr = $urandom;
      mem_ready = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    n_cmp++;
    if ({mem_req, mem_we, mem_wstrb, resp_valid, resp_misaligned} !== 8'h0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b exp 0",
                         {mem_req, mem_we, mem_wstrb, resp_valid, resp_misaligned});
    end
    n_cmp++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_bus: got addr %h wdata %h exp 0", mem_addr, mem_wdata);
    end
    n_cmp++;
    if (resp_data !== 32'h0 || amo_rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_data: got resp %h amo %h exp 0", resp_data, amo_rdata);
    end
    rst = 1'b0;
    req_valid = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b exp 1", req_ready);
    end
  endtask

  task automatic test_load();
    obs_t o;
    run_op(LB, 32'h1003, 32'h0, 32'h80AA_BBCC, 0, 0, o);
    n_cmp++;
    if (o.raddr !== 32'h1000 || o.resp_cyc != 2 || o.data !== 32'hFFFF_FF80) begin
      n_fail++; $display("FAIL lb: got addr %h cyc %0d data %h exp 1000 2 ffffff80",
                         o.raddr, o.resp_cyc, o.data);
    end
    run_op(LBU, 32'h1003, 32'h0, 32'h80AA_BBCC, 0, 0, o);
    n_cmp++;
    if (o.resp_cyc != 2 || o.data !== 32'h0000_0080 || o.mis !== 1'b0) begin
      n_fail++; $display("FAIL lbu: got cyc %0d data %h exp 2 00000080", o.resp_cyc, o.data);
    end
  endtask

  task automatic test_store();
    obs_t o;
    run_op(SH, 32'h2002, 32'h1234_ABCD, 32'h0, 0, 0, o);
    n_cmp++;
    if (o.nwr != 1 || o.nrd != 0 || o.wstrb !== 4'b1100 || o.wdat !== 32'hABCD_ABCD) begin
      n_fail++; $display("FAIL sh_bus: got wr %0d rd %0d strb %b wdata %h exp 1 0 1100 abcdabcd",
                         o.nwr, o.nrd, o.wstrb, o.wdat);
    end
    n_cmp++;
    if (o.resp_cyc != 2 || o.data !== 32'h0 || o.waddr !== 32'h2000) begin
      n_fail++; $display("FAIL sh_resp: got cyc %0d data %h addr %h exp 2 0 2000",
                         o.resp_cyc, o.data, o.waddr);
    end
  endtask

  task automatic test_misaligned();
    obs_t o;
    run_op(LW, 32'h3001, 32'h0, 32'h5555_5555, 0, 0, o);
    n_cmp++;
    if (o.resp_cyc != 1 || o.mis !== 1'b1 || o.data !== 32'h0 || o.nrd + o.nwr != 0) begin
      n_fail++; $display("FAIL lw_mis: got cyc %0d mis %b data %h bus %0d exp 1 1 0 0",
                         o.resp_cyc, o.mis, o.data, o.nrd + o.nwr);
    end
    run_op(SH, 32'h3001, 32'h1111, 32'h0, 0, 0, o);
    n_cmp++;
    if (o.resp_cyc != 1 || o.mis !== 1'b1 || o.nwr != 0) begin
      n_fail++; $display("FAIL sh_mis: got cyc %0d mis %b wr %0d exp 1 1 0",
                         o.resp_cyc, o.mis, o.nwr);
    end
    run_op(SB, 32'h3001, 32'h0000_00A5, 32'h0, 0, 0, o);
    n_cmp++;
    if (o.resp_cyc != 2 || o.mis !== 1'b0 || o.wstrb !== 4'b0010 || o.wdat !== 32'hA5A5_A5A5)
    begin
      n_fail++; $display("FAIL sb_ok: got cyc %0d mis %b strb %b wdata %h exp 2 0 0010 a5a5a5a5",
                         o.resp_cyc, o.mis, o.wstrb, o.wdat);
    end
  endtask

  task automatic test_amo();
    obs_t o;
    run_op(AMO, 32'h4000, 32'd7, 32'd5, 0, 0, o);
    n_cmp++;
    if (o.amo_seen !== 32'd5) begin
      n_fail++; $display("FAIL amo_calc: got amo_rdata %h exp 5", o.amo_seen);
    end
    n_cmp++;
    if (o.wdat !== 32'd12 || o.wstrb !== 4'b1111 || o.waddr !== 32'h4000) begin
      n_fail++; $display("FAIL amo_write: got wdata %h strb %b addr %h exp c 1111 4000",
                         o.wdat, o.wstrb, o.waddr);
    end
    n_cmp++;
    if (o.resp_cyc != 4 || o.data !== 32'd5) begin
      n_fail++; $display("FAIL amo_resp: got cyc %0d data %h exp 4 5", o.resp_cyc, o.data);
    end
  endtask

  task automatic test_wait();
    obs_t o;
    run_op(LW, 32'h3004, 32'h0, 32'hCAFE_F00D, 3, 0, o);
    n_cmp++;
    if (o.resp_cyc != 5 || o.data !== 32'hCAFE_F00D) begin
      n_fail++; $display("FAIL lw_wait: got cyc %0d data %h exp 5 cafef00d", o.resp_cyc, o.data);
    end
    n_cmp++;
    if (o.stable !== 1'b1 || o.rdy_low !== 1'b1 || o.idle_after !== 1'b1 || o.nrd != 1) begin
      n_fail++; $display("FAIL lw_wait_bus: got stable %b rdy_low %b idle %b rd %0d exp 1 1 1 1",
                         o.stable, o.rdy_low, o.idle_after, o.nrd);
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    bit   pulse;
    @(negedge clk);
    req_valid = 1'b1;
    lsu_op = SW;
    addr = 32'h5004;
    wdata = 32'h0BAD_F00D;
    mem_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    n_cmp++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_write: got req %b we %b exp 1 1", mem_req, mem_we);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (mem_req !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid: got req %b ready %b resp %b exp 0 1 0",
                         mem_req, req_ready, resp_valid);
    end
    pulse = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (resp_valid) pulse = 1;
    end
    n_cmp++;
    if (pulse) begin
      n_fail++; $display("FAIL rst_mid_pulse: got resp_valid 1 exp 0");
    end
    run_op(LHU, 32'h6002, 32'h0, 32'h8765_4321, 1, 0, o);
    n_cmp++;
    if (o.resp_cyc != 3 || o.data !== 32'h0000_8765) begin
      n_fail++; $display("FAIL rst_mid_after: got cyc %0d data %h exp 3 8765", o.resp_cyc, o.data);
    end
  endtask

  task automatic test_random();
    logic [3:0]  ops[9] = '{LB, LH, LW, LBU, LHU, SB, SH, SW, AMO};
    obs_t        o;
    logic [3:0]  op;
    logic [31:0] a, wd, rd, e_data;
    int          rw, ww, e_cyc;
    bit          mis, ld, st, am;
    for (int t = 0; t < 80; t++) begin
      op = ops[$urandom_range(0, 8)];
      a  = $urandom;
      if ($urandom_range(0, 1) == 1) a = a - (a % 4);
      wd = $urandom;
      rd = $urandom;
      rw = $urandom_range(0, 3);
      ww = $urandom_range(0, 3);
      run_op(op, a, wd, rd, rw, ww, o);
      mis = model_mis(op, a);
      ld  = is_load(op);
      st  = is_st(op);
      am  = (op == AMO);
      e_cyc  = mis ? 1 : am ? 4 + rw + ww : st ? 2 + ww : 2 + rw;
      e_data = mis ? 32'h0 : ld ? model_load(op, a, rd) : am ? rd : 32'h0;
      n_cmp++;
      if (o.resp_cyc != e_cyc || o.data !== e_data || o.mis !== mis) begin
        n_fail++; $display("FAIL rnd_resp[%0d] op %0d addr %h: got cyc %0d data %h mis %b exp %0d %h %b",
                           t, op, a, o.resp_cyc, o.data, o.mis, e_cyc, e_data, mis);
      end
      n_cmp++;
      if (o.nrd != int'(!mis && (ld || am)) || o.nwr != int'(!mis && (st || am))) begin
        n_fail++; $display("FAIL rnd_bus[%0d] op %0d: got rd %0d wr %0d", t, op, o.nrd, o.nwr);
      end
      if (!mis && (st || am)) begin
        n_cmp++;
        if (o.waddr !== a - (a % 4) || o.wstrb !== model_strb(op, a) ||
            o.wdat !== (am ? rd + wd : model_wdata(op, wd))) begin
          n_fail++; $display("FAIL rnd_write[%0d] op %0d addr %h: got addr %h strb %b wdata %h",
                             t, op, a, o.waddr, o.wstrb, o.wdat);
        end
      end
      if (!mis && (ld || am)) begin
        n_cmp++;
        if (o.raddr !== a - (a % 4)) begin
          n_fail++; $display("FAIL rnd_raddr[%0d]: got %h exp %h", t, o.raddr, a - (a % 4));
        end
      end
      n_cmp++;
      if (o.stable !== 1'b1 || o.rdy_low !== 1'b1 || o.idle_after !== 1'b1) begin
        n_fail++; $display("FAIL rnd_hs[%0d]: got stable %b rdy_low %b idle %b exp 1 1 1",
                           t, o.stable, o.rdy_low, o.idle_after);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    lsu_op = 4'h0;
    addr = 32'h0;
    wdata = 32'h0;
    alu_b = 32'h0;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    test_reset();
    test_load();
    test_store();
    test_misaligned();
    test_amo();
    test_wait();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/core_lsu.md
Name: core_lsu

Overview:
- Load/store unit in the execute/memory stage; directly downstream of the ALU.
- Consumes the ALU sum (base + offset) as the effective address.
- Performs byte/half/word loads and stores over a single-outstanding memory bus.
- For word AMOs, feeds the loaded value back to the ALU as an operand and writes the ALU's combinational result back to memory.

Parameters:
none (XLEN fixed at 32)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  unit can accept; high only in IDLE
lsu_op  in  4  0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU, 8 SB, 9 SH, 10 SW, 14 AMO; other codes never issued
addr  in  32  effective address from ALU
wdata  in  32  store data (rs2)
amo_rdata  out  32  latched AMO read value, ALU src_a operand
amo_wdata  in  32  ALU result for AMO write-back
mem_req  out  1  bus request
mem_we  out  1  write enable
mem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
mem_wstrb  out  4  byte strobes
mem_wdata  out  32  write data
mem_ready  in  1  one-cycle acknowledge; mem_rdata valid in the same cycle
mem_rdata  in  32  read data
resp_valid  out  1  one-cycle completion pulse
resp_data  out  32  load result (extended), AMO old value, or 0 for stores
resp_misaligned  out  1  misaligned fault; qualified by resp_valid

Behaviour:
- FSM states: IDLE, READ, CALC, WRITE, RESP.
- Reset: state IDLE, all outputs and registers 0.
- Accept: request is taken when req_valid && req_ready. On accept, latch addr, lsu_op and wdata.
- Misalignment check at accept:
  - LH/LHU/SH: fault if addr[0]=1.
  - LW/SW/AMO: fault if addr[1:0]!=0.
  - On fault, go to RESP with resp_misaligned=1, resp_data=0. No bus access.
- Loads and AMO go to READ; stores go to WRITE.
- READ:
  - mem_req=1, mem_we=0.
  - On mem_ready: capture mem_rdata. Loads go to RESP; AMO goes to CALC.
- CALC (AMO only):
  - Exactly one cycle; amo_rdata holds the read word.
  - At the end of the cycle, latch amo_wdata as the write data and the old value as the response, then go to WRITE.
- WRITE:
  - mem_req=1, mem_we=1.
  - On mem_ready, go to RESP.
- RESP: resp_valid=1 for one cycle, then IDLE. req_ready stays 0 in RESP.
- Bus stability: mem_addr, mem_we, mem_wstrb and mem_wdata are held stable while mem_req=1 until mem_ready. mem_req is 0 in IDLE, CALC and RESP.
- Store formatting (k = addr[1:0]):
  - SB: wstrb = 4'b0001<<k; wdata byte replicated x4.
  - SH: wstrb = 4'b0011<<(2*addr[1]); half replicated x2.
  - SW/AMO: wstrb = 4'b1111.
- Load formatting:
  - Shift rdata right by 8*k.
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW uses rdata unchanged.
- Latency (accept in cycle 0):
  - Misaligned: resp_valid in cycle 1.
  - Load or store with immediate mem_ready: resp_valid in cycle 2.
  - AMO with immediate ready: READ c1, CALC c2, WRITE c3, resp_valid c4.
  - Each extra wait cycle on the bus adds one cycle.
- mem_ready outside READ/WRITE is ignored.
- rst during any state: IDLE on the next edge, mem_req=0, no resp_valid. A pending bus transaction is abandoned; the memory side is reset together with the core.

Test Plan:
- LB addr=0x1003, rdata=0x80AA_BBCC, ready immediate -> mem_addr=0x1000, resp_data=0xFFFFFF80 two cycles after accept; LBU same -> 0x00000080.
- SH addr=0x2002, wdata=0x1234_ABCD -> mem_we=1, wstrb=4'b1100, mem_wdata=0xABCD_ABCD; resp_valid with resp_data=0.
- LW addr=0x3001 -> resp_valid next cycle with resp_misaligned=1; mem_req never asserts. SH addr=0x3001 also faults; SB addr=0x3001 does not.
- AMO (ALU=ADD) addr=0x4000, rdata=5, rs2=7 -> amo_rdata=5 in CALC, write mem_wdata=12 with wstrb=4'b1111, resp_data=5 at cycle 4.
- LW with mem_ready delayed 3 cycles -> mem_req and mem_addr stable across the wait, resp_valid at cycle 5, req_ready low throughout.
- rst asserted in WRITE with mem_ready low -> next cycle state IDLE, mem_req=0, req_ready=1, no resp_valid pulse; a new request is accepted normally afterwards.
